accum_drain: RTL and testbench

Drain sequencer for the accumulation table. On `start` it reads a contiguous range of accumulator rows (all `SYS_ARR_COLS` columns in parallel) and streams each row out over a valid/ready interface toward the output buffer. When done it can optionally zero the table with a one-cycle `clear` pulse. It sits between the accumulation table's read port and the output write-back path, and it is the only agent driving the table's `rd_en`, `rd_addr` and `clear`.

---
 rtl/accum_drain.sv | 164 ++++++++++++++++
 tb/tb_accum_drain.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/accum_drain.sv
// accum_drain
//   Drain sequencer for the accumulation table. On an accepted start it reads
//   num_rows consecutive table rows (wrapping past the top row), buffers the
//   read data in a 2-entry FIFO and streams each row out as one beat. When the
//   last beat has been accepted it spends one CLEAR cycle (pulsing tbl_clear if
//   clear_en was set at start) and one DONE cycle (done pulse), then returns
//   to IDLE.
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   start           job request, honoured only in IDLE
//   base_addr       first row of the job (sampled on accepted start)
//   num_rows        rows to drain, 0..NUM_ACCUM_ROWS (sampled on start)
//   clear_en        zero the table after draining (sampled on start)
//   busy            high in DRAIN and CLEAR
//   done            one-cycle pulse in DONE
//   tbl_rd_en       per-column read enable (all bits identical)
//   tbl_rd_addr     row address replicated per column
//   tbl_rd_data     table read data, valid one cycle after tbl_rd_en
//   tbl_clear       per-column clear (all bits identical)
//   out_valid/out_ready/out_data/out_last  output beat stream
//
// Handshake: a beat transfers on a rising clk edge where out_valid and
// out_ready are both high. Once out_valid rises it stays high, with out_data
// and out_last unchanged, until that transfer happens. out_ready may be
// changed freely by the consumer.

module accum_drain #(
  parameter int DATA_WIDTH     = 16,
  parameter int MAX_OUT_ROWS   = 128,
  parameter int MAX_OUT_COLS   = 128,
  parameter int SYS_ARR_COLS   = 16,
  localparam int NUM_ACCUM_ROWS = MAX_OUT_ROWS * (MAX_OUT_COLS / SYS_ARR_COLS),
  localparam int ADDR_W         = $clog2(NUM_ACCUM_ROWS)
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               start,
  input  logic [ADDR_W-1:0]                  base_addr,
  input  logic [ADDR_W:0]                    num_rows,
  input  logic                               clear_en,
  output logic                               busy,
  output logic                               done,
  output logic [SYS_ARR_COLS-1:0]            tbl_rd_en,
  output logic [ADDR_W*SYS_ARR_COLS-1:0]     tbl_rd_addr,
  input  logic [DATA_WIDTH*SYS_ARR_COLS-1:0] tbl_rd_data,
  output logic [SYS_ARR_COLS-1:0]            tbl_clear,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [DATA_WIDTH*SYS_ARR_COLS-1:0] out_data,
  output logic                               out_last
);

  localparam int RW = DATA_WIDTH * SYS_ARR_COLS;
  localparam logic [ADDR_W:0]   ONE_R     = 1;
  localparam logic [ADDR_W-1:0] ONE_A     = 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_ACCUM_ROWS - 1);

  typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_CLEAR, S_DONE} state_t;

  state_t            state_q;
  logic [ADDR_W:0]   num_rows_q;
  logic              clr_en_q;
  logic [ADDR_W-1:0] addr_q;      // address of the next read to issue
  logic [ADDR_W:0]   issued_q;    // reads issued so far in this job
  logic [ADDR_W:0]   beats_q;     // beats accepted so far in this job
  logic              pend_q;      // read issued last cycle, data on tbl_rd_data now
  logic              pend_last_q; // that read was row num_rows-1
  logic [RW-1:0]     data_q [2];
  logic              last_q [2];
  logic              wr_ptr_q;
  logic              rd_ptr_q;
  logic [1:0]        cnt_q;

  logic              pop;
  logic              rd_go;
  logic [2:0]        occ;
  logic [1:0]        cnt_d;
  logic [ADDR_W-1:0] addr_d;

  // The read decided this cycle lands in the FIFO at the end of the next
  // cycle, so the only other unbuffered row is pend_q. Issuing while
  // (FIFO + pend - pop) < 2 keeps the FIFO within 2 entries yet still allows
  // one read per cycle when every beat is accepted.
  always_comb begin
    pop    = (cnt_q != 2'd0) & out_ready;
    occ    = {1'b0, cnt_q} + {2'b00, pend_q};
    rd_go  = (state_q == S_DRAIN) && (issued_q < num_rows_q) &&
             (occ < (3'd2 + {2'b00, pop}));
    cnt_d  = cnt_q + {1'b0, pend_q} - {1'b0, pop};
    addr_d = (addr_q == LAST_ADDR) ? '0 : addr_q + ONE_A;
  end

  assign busy        = (state_q == S_DRAIN) || (state_q == S_CLEAR);
  assign done        = (state_q == S_DONE);
  assign tbl_rd_en   = {SYS_ARR_COLS{rd_go}};
  assign tbl_rd_addr = {SYS_ARR_COLS{addr_q}};
  assign tbl_clear   = {SYS_ARR_COLS{(state_q == S_CLEAR) && clr_en_q}};
  assign out_valid   = (cnt_q != 2'd0);
  assign out_data    = data_q[rd_ptr_q];
  assign out_last    = out_valid & last_q[rd_ptr_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      num_rows_q  <= '0;
      clr_en_q    <= 1'b0;
      addr_q      <= '0;
      issued_q    <= '0;
      beats_q     <= '0;
      pend_q      <= 1'b0;
      pend_last_q <= 1'b0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      cnt_q       <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        data_q[i] <= '0;
        last_q[i] <= 1'b0;
      end
    end else begin
      pend_q      <= rd_go;
      pend_last_q <= rd_go & (issued_q == num_rows_q - ONE_R);
      cnt_q       <= cnt_d;

      if (pend_q) begin
        data_q[wr_ptr_q] <= tbl_rd_data;
        last_q[wr_ptr_q] <= pend_last_q;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      if (rd_go) begin
        addr_q   <= addr_d;
        issued_q <= issued_q + ONE_R;
      end

      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            num_rows_q <= num_rows;
            clr_en_q   <= clear_en;
            addr_q     <= base_addr;
            issued_q   <= '0;
            beats_q    <= '0;
            state_q    <= (num_rows == '0) ? S_CLEAR : S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (pop) begin
            beats_q <= beats_q + ONE_R;
            if (beats_q == num_rows_q - ONE_R) begin
              state_q <= S_CLEAR;
            end
          end
        end
        S_CLEAR: state_q <= S_DONE;
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_accum_drain.sv
// Testbench for accum_drain: table-driven job vectors plus a hand-written
// reset-in-the-middle sequence. A behavioural table model returns a known
// pattern one cycle after each read; expected beats are queued per job.

module tb_accum_drain;

  localparam int DW    = 16;
  localparam int COLS  = 16;
  localparam int NUM   = 1024;
  localparam int AW    = 10;
  localparam int RW    = DW * COLS;
  localparam int W     = RW + 1;

  logic                 clk;
  logic                 rst_n;
  logic                 start;
  logic [AW-1:0]        base_addr;
  logic [AW:0]          num_rows;
  logic                 clear_en;
  logic                 busy;
  logic                 done;
  logic [COLS-1:0]      tbl_rd_en;
  logic [AW*COLS-1:0]   tbl_rd_addr;
  logic [RW-1:0]        tbl_rd_data;
  logic [COLS-1:0]      tbl_clear;
  logic                 out_valid;
  logic                 out_ready;
  logic [RW-1:0]        out_data;
  logic                 out_last;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [W-1:0] exp_q[$];

  accum_drain dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .base_addr  (base_addr),
    .num_rows   (num_rows),
    .clear_en   (clear_en),
    .busy       (busy),
    .done       (done),
    .tbl_rd_en  (tbl_rd_en),
    .tbl_rd_addr(tbl_rd_addr),
    .tbl_rd_data(tbl_rd_data),
    .tbl_clear  (tbl_clear),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- table model ----------------
  function automatic logic [RW-1:0] row_of(input int a);
    logic [RW-1:0] r;
    logic [9:0]    aa;
    logic [3:0]    cc;
    aa = a[9:0];
    for (int c = 0; c < COLS; c++) begin
      cc = c[3:0];
      r[c*DW +: DW] = {cc, 2'b01, aa};
    end
    return r;
  endfunction

  always @(posedge clk) begin
    if (tbl_rd_en[0]) tbl_rd_data <= row_of(int'(tbl_rd_addr[AW-1:0]));
    else              tbl_rd_data <= {COLS{16'hDEAD}};
  end

  // ---------------- checkers ----------------
  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_reset_vals();
    chk("rst_busy",    W'(busy),        '0);
    chk("rst_done",    W'(done),        '0);
    chk("rst_rd_en",   W'(tbl_rd_en),   '0);
    chk("rst_rd_addr", W'(tbl_rd_addr), '0);
    chk("rst_clear",   W'(tbl_clear),   '0);
    chk("rst_valid",   W'(out_valid),   '0);
    chk("rst_last",    W'(out_last),    '0);
  endtask

  // ---------------- job vectors ----------------
  // mode: 0 = ready always high, 1 = ready 1,0,0 repeating, 2 = random ready
  // lat : expected start-to-done cycles (only meaningful for mode 0, else -1)
  // poke: cycle (relative to start) at which a different start is pulsed, 0 = none
  typedef struct {
    int base;
    int n;
    bit clr;
    int mode;
    int lat;
    int poke;
  } vec_t;

  task automatic run_job(input vec_t v);
    int done_k  = -1;
    int clear_k = -1;
    int reads   = 0;
    int beats   = 0;
    int budget;
    bit stall   = 0;
    logic [W-1:0] prev = '0;
    logic [W-1:0] got;
    logic [AW-1:0] ea;
    exp_q.delete();
    for (int i = 0; i < v.n; i++)
      exp_q.push_back({(i == v.n - 1) ? 1'b1 : 1'b0, row_of((v.base + i) % NUM)});
    budget = v.n * 4 + 20;
    for (int k = 0; k < budget; k++) begin
      @(posedge clk); #1;
      if (k == 0) begin
        start = 1'b1; base_addr = AW'(v.base); num_rows = (AW+1)'(v.n); clear_en = v.clr;
      end else if (v.poke != 0 && k == v.poke) begin
        start = 1'b1; base_addr = AW'(v.base + 77); num_rows = 3; clear_en = ~v.clr;
      end else begin
        start = 1'b0;
      end
      case (v.mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (k % 3 == 0);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      @(negedge clk);
      if (v.mode == 0) chk("busy", W'(busy), W'(k >= 1 && k < v.lat));
      else             chk("busy", W'(busy), W'(k >= 1 && !done));
      if (tbl_rd_en != '0) begin
        ea = AW'((v.base + reads) % NUM);
        chk("rd_en_all", W'(tbl_rd_en), W'({COLS{1'b1}}));
        chk("rd_addr", W'(tbl_rd_addr), W'({COLS{ea}}));
        if (v.mode == 0) chk_int("rd_cycle", k, reads + 1);
        reads++;
        chk_int("rd_overrun", reads > v.n, 0);
      end
      if (!out_valid) chk("last_wo_valid", W'(out_last), '0);
      if (stall) chk("stall_hold", {out_last, out_data}, prev);
      if (out_valid && out_ready) begin
        got = {out_last, out_data};
        if (exp_q.size() == 0) chk("extra_beat", got, '0);
        else                   chk("beat", got, exp_q.pop_front());
        if (v.mode == 0) chk_int("beat_cycle", k, beats + 3);
        beats++;
      end
      chk_int("outstanding", (reads - beats > 2) ? 1 : 0, 0);
      stall = out_valid && !out_ready;
      prev  = {out_last, out_data};
      if (tbl_clear != '0) begin
        chk("clear_val", W'(tbl_clear), v.clr ? W'({COLS{1'b1}}) : '0);
        clear_k = k;
      end
      if (done) begin
        done_k = k;
        break;
      end
    end
    if (done_k < 0) chk_int("done_timeout", 0, 1);
    if (v.lat >= 0) chk_int("done_lat", done_k, v.lat);
    chk_int("clear_cycle", clear_k, v.clr ? done_k - 1 : -1);
    chk_int("reads", reads, v.n);
    chk_int("beats", beats, v.n);
    chk_int("exp_left", exp_q.size(), 0);
    // two idle cycles: single done pulse, nothing restarted
    for (int j = 0; j < 2; j++) begin
      @(posedge clk); #1;
      start = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      chk("post_idle", W'({done, busy, out_valid, tbl_rd_en[0], tbl_clear[0]}), '0);
    end
  endtask

  vec_t vecs[10];

  initial begin
    int beats;
    vecs[0] = '{base: 0,    n: 4,    clr: 1, mode: 0, lat: 8,    poke: 0};
    vecs[1] = '{base: 1022, n: 4,    clr: 0, mode: 0, lat: 8,    poke: 0};
    vecs[2] = '{base: 16,   n: 8,    clr: 1, mode: 1, lat: -1,   poke: 0};
    vecs[3] = '{base: 0,    n: 0,    clr: 0, mode: 0, lat: 2,    poke: 0};
    vecs[4] = '{base: 40,   n: 0,    clr: 1, mode: 0, lat: 2,    poke: 0};
    vecs[5] = '{base: 200,  n: 5,    clr: 1, mode: 0, lat: 9,    poke: 2};
    vecs[6] = '{base: 900,  n: 3,    clr: 0, mode: 0, lat: 7,    poke: 7};
    vecs[7] = '{base: 1000, n: 30,   clr: 1, mode: 2, lat: -1,   poke: 0};
    vecs[8] = '{base: 5,    n: 1,    clr: 0, mode: 0, lat: 5,    poke: 0};
    vecs[9] = '{base: 3,    n: 1024, clr: 1, mode: 0, lat: 1028, poke: 0};

    rst_n = 1'b0; start = 1'b0; base_addr = '0; num_rows = '0;
    clear_en = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_vals();
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) run_job(vecs[i]);

    // reset mid-drain after three accepted beats
    @(posedge clk); #1;
    start = 1'b1; base_addr = 10'd50; num_rows = 11'd8; clear_en = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    beats = 0;
    for (int k = 0; k < 30 && beats < 3; k++) begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        chk("abort_beat", {out_last, out_data}, {1'b0, row_of(50 + beats)});
        beats++;
      end
    end
    chk_int("abort_reached", beats, 3);
    #2 rst_n = 1'b0;
    #1 chk_reset_vals();
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      chk("abort_quiet", W'({done, tbl_clear[0], out_valid, busy}), '0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_job('{base: 300, n: 2, clr: 1, mode: 0, lat: 6, poke: 0});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
